// File: rtl/pipe_if_stage_pkg.sv
// rtl/pipe_if_stage_pkg.sv - shared pipeline types and constants for the IF stage and its neighbours
package pipe_if_stage_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // sll $0,$0,0
  localparam word_t NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_npc_mux.sv
// rtl/pipe_npc_mux.sv - next-PC 4:1 select with word-alignment force and misalignment detect
module pipe_npc_mux
  import pipe_if_stage_pkg::*;
(
  input  logic [1:0] pcsource,
  input  word_t      pc4,
  input  word_t      bpc,
  input  word_t      da,
  input  word_t      jpc,
  output word_t      npc,
  output logic       misaligned
);

  word_t raw_npc;

  // Select the target, then force word alignment and flag any dropped low bits.
  always_comb begin
    raw_npc = pc4;
    unique case (pcsource)
      PCSRC_SEQ: raw_npc = pc4;
      PCSRC_BR:  raw_npc = bpc;
      PCSRC_JR:  raw_npc = da;
      PCSRC_J:   raw_npc = jpc;
      default:   raw_npc = pc4;
    endcase
    npc        = {raw_npc[31:2], 2'b00};
    misaligned = (raw_npc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - MIPS IF stage and IF/ID register; PIPE_IF_DELAY_SLOT_EN selects delay-slot mode
module pipe_if_stage
  import pipe_if_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter word_t NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  word_t npc;
  logic  npc_misaligned;
  logic  squash;

  assign pc4 = pc + 32'd4;

  pipe_npc_mux u_npc_mux (
    .pcsource   (pcsource),
    .pc4        (pc4),
    .bpc        (bpc),
    .da         (da),
    .jpc        (jpc),
    .npc        (npc),
    .misaligned (npc_misaligned)
  );

`ifdef PIPE_IF_DELAY_SLOT_EN
  // The slot fetched alongside a redirect is the architectural delay slot.
  assign squash = 1'b0;
`else
  // The slot fetched alongside a redirect is on the wrong path.
  assign squash = (pcsource != PCSRC_SEQ);
`endif

  // PC, IF/ID register, sticky misalign flag and fetch counter; a stall holds everything.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc        <= RESET_PC;
      inst      <= NOP_INST;
      dpc4      <= 32'd0;
      dvalid    <= 1'b0;
      misalign  <= 1'b0;
      fetch_cnt <= 32'd0;
    end else if (wpcir) begin
      pc   <= npc;
      dpc4 <= pc4;
      if (npc_misaligned) begin
        misalign <= 1'b1;
      end
      if (squash) begin
        inst   <= NOP_INST;
        dvalid <= 1'b0;
      end else begin
        inst      <= imem_inst;
        dvalid    <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule
